// File: rtl/logbar_frame_scheduler.sv
// rtl/logbar_frame_scheduler.sv - log-bar converter sequencer with peak-hold/decay for one stereo frame
//
// Purpose:
//   On each accepted frame start, walks every bin (left channel, then right),
//   reads its magnitude, runs it through the shared log-bar converter, merges
//   the 7-bit result with the previous bar height (peak hold with a fixed
//   per-frame decay) and writes the merged height back to the bar RAM.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_frame_start    single-cycle pulse, new magnitude frame available
//   o_busy           frame in progress (READ..DONE)
//   o_frame_done     single-cycle pulse in the cycle after the last bar write
//   o_overrun        single-cycle pulse, frame start seen while busy
//   o_timeout_err    sticky converter-timeout flag, cleared only by reset
//   o_mag_rd         magnitude RAM read strobe
//   o_mag_addr       magnitude RAM address {channel, bin}
//   i_mag_data       magnitude RAM data, valid the cycle after o_mag_rd
//   o_cv_start       converter start pulse
//   o_cv_in          converter operand, stable while converting
//   i_cv_out         converter result, valid with i_cv_end
//   i_cv_end         converter done pulse
//   o_bar_addr       bar RAM address {channel, bin}, shared by read and write
//   i_bar_q          bar RAM read data, valid the cycle after the address
//   o_bar_we         bar RAM write enable
//   o_bar_data       bar RAM write data

module logbar_frame_scheduler #(
  parameter int bw_input   = 18,
  parameter int n_bins     = 64,
  parameter int bw_addr    = 6,
  parameter int decay_step = 1,
  parameter int timeout    = 63
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_start,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_overrun,
  output logic                o_timeout_err,
  output logic                o_mag_rd,
  output logic [bw_addr:0]    o_mag_addr,
  input  logic [bw_input-1:0] i_mag_data,
  output logic                o_cv_start,
  output logic [bw_input-1:0] o_cv_in,
  input  logic [6:0]          i_cv_out,
  input  logic                i_cv_end,
  output logic [bw_addr:0]    o_bar_addr,
  input  logic [6:0]          i_bar_q,
  output logic                o_bar_we,
  output logic [6:0]          o_bar_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [15:0]        c_timeout  = 16'(timeout);
  localparam logic [6:0]         c_decay    = 7'(decay_step);
  localparam logic [bw_addr-1:0] c_last_bin = bw_addr'(n_bins - 1);
  localparam logic [bw_addr-1:0] c_bin_one  = bw_addr'(1);

  logic [2:0]          r_state;
  logic [bw_addr-1:0]  r_bin;
  logic                r_ch;
  logic [15:0]         r_cnt;
  logic [bw_addr:0]    r_addr;
  logic [bw_input-1:0] r_cv_in;
  logic [6:0]          r_old;
  logic [6:0]          r_bar_data;
  logic                r_timeout_err;
  logic                r_overrun;

  logic [15:0]         w_cnt_inc;
  logic [6:0]          w_decayed;
  logic [6:0]          w_res;
  logic [6:0]          w_merged;
  logic [bw_addr-1:0]  w_bin_next;

  assign w_cnt_inc  = r_cnt + 16'd1;
  assign w_bin_next = r_bin + c_bin_one;

  // Decayed previous height, floored at zero.
  assign w_decayed = (r_old > c_decay) ? (r_old - c_decay) : 7'd0;
  // A timed-out conversion contributes a result of zero, so the bar just decays.
  assign w_res     = i_cv_end ? i_cv_out : 7'd0;
  assign w_merged  = (w_res > w_decayed) ? w_res : w_decayed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_bin         <= '0;
      r_ch          <= 1'b0;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_cv_in       <= '0;
      r_old         <= '0;
      r_bar_data    <= '0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_overrun <= i_frame_start && (r_state != S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (i_frame_start) begin
            r_bin   <= '0;
            r_ch    <= 1'b0;
            r_addr  <= '0;
            r_state <= S_READ;
          end
        end

        S_READ: begin
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          r_cv_in <= i_mag_data;
          r_old   <= i_bar_q;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          // Comparing the incremented count makes the write land exactly
          // timeout+1 cycles after the converter start.
          if (i_cv_end) begin
            r_bar_data <= w_merged;
            r_state    <= S_WRITE;
          end else if (w_cnt_inc == c_timeout) begin
            r_bar_data    <= w_merged;
            r_timeout_err <= 1'b1;
            r_state       <= S_WRITE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_WRITE: begin
          if (!r_ch) begin
            r_ch    <= 1'b1;
            r_addr  <= {1'b1, r_bin};
            r_state <= S_READ;
          end else if (r_bin != c_last_bin) begin
            r_ch    <= 1'b0;
            r_bin   <= w_bin_next;
            r_addr  <= {1'b0, w_bin_next};
            r_state <= S_READ;
          end else begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_frame_done  = (r_state == S_DONE);
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;
  assign o_mag_rd      = (r_state == S_READ);
  assign o_mag_addr    = r_addr;
  assign o_bar_addr    = r_addr;
  assign o_cv_start    = (r_state == S_LATCH);
  // Operand is passed straight through in the start cycle so the converter
  // sees it together with the start pulse; the register holds it afterwards.
  assign o_cv_in       = (r_state == S_LATCH) ? i_mag_data : r_cv_in;
  assign o_bar_we      = (r_state == S_WRITE);
  assign o_bar_data    = r_bar_data;

endmodule

// File: tb/tb_logbar_frame_scheduler.sv
// tb/tb_logbar_frame_scheduler.sv - directed bench for logbar_frame_scheduler

module tb_logbar_frame_scheduler;

  localparam int bw_input   = 18;
  localparam int n_bins     = 4;
  localparam int bw_addr    = 2;
  localparam int decay_step = 1;
  localparam int timeout    = 63;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                frame_start = 1'b0;
  logic                busy, frame_done, overrun, timeout_err;
  logic                mag_rd, cv_start, bar_we;
  logic [bw_addr:0]    mag_addr, bar_addr;
  logic [bw_input-1:0] mag_data = '0;
  logic [bw_input-1:0] cv_in;
  logic [6:0]          cv_out = '0;
  logic                cv_end = 1'b0;
  logic [6:0]          bar_q = '0;
  logic [6:0]          bar_data;

  always #5 clk = ~clk;

  logbar_frame_scheduler #(
    .bw_input(bw_input), .n_bins(n_bins), .bw_addr(bw_addr),
    .decay_step(decay_step), .timeout(timeout)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
    .o_busy(busy), .o_frame_done(frame_done), .o_overrun(overrun),
    .o_timeout_err(timeout_err), .o_mag_rd(mag_rd), .o_mag_addr(mag_addr),
    .i_mag_data(mag_data), .o_cv_start(cv_start), .o_cv_in(cv_in),
    .i_cv_out(cv_out), .i_cv_end(cv_end), .o_bar_addr(bar_addr),
    .i_bar_q(bar_q), .o_bar_we(bar_we), .o_bar_data(bar_data)
  );

  // RAM contents, written only by the main stimulus block.
  logic [bw_input-1:0] mag_mem [8];
  logic [6:0]          bar_mem [8];

  // Environment state, written only by the environment block.
  int              cyc = 0, n_wr = 0, n_busy = 0, n_done = 0, n_ovr = 0;
  int              busy_rise = 0, done_cyc = 0, last_start = 0, cv_cnt = 0;
  logic            prev_busy = 1'b0;
  logic [6:0]      cv_hold = '0;
  logic [bw_addr:0] wr_addr [64];
  logic [6:0]      wr_data [64];
  int              wr_lat  [64];

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // RAM models, converter model (latency 3, operand 18'h3FFFF never completes)
  // and event recorder, all sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      cv_end = 1'b0;
      if (bar_we && n_wr < 64) begin
        wr_addr[n_wr] = bar_addr;
        wr_data[n_wr] = bar_data;
        wr_lat[n_wr]  = cyc - last_start;
        n_wr++;
      end
      if (mag_rd) mag_data = mag_mem[mag_addr];
      bar_q = bar_mem[bar_addr];
      if (!rst_n) cv_cnt = 0;
      if (cv_cnt > 0) begin
        cv_cnt--;
        if (cv_cnt == 0) begin
          cv_end = 1'b1;
          cv_out = cv_hold;
        end
      end
      if (cv_start) begin
        last_start = cyc;
        if (cv_in != 18'h3FFFF) begin
          cv_cnt  = 3;
          cv_hold = cv_in[6:0];
        end
      end
      if (busy && !prev_busy) busy_rise = cyc;
      prev_busy = busy;
      if (busy) n_busy++;
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (overrun) n_ovr++;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  logic [6:0] f2_bar [8];
  logic [6:0] f2_mag [8];
  logic [6:0] f2_exp [8];

  initial begin
    logic seen;
    int   base, b0, d0, o0, w0;

    // Per address {ch,bin}: previous height, converter result, merged height.
    f2_bar = '{7'd80, 7'd10, 7'd127, 7'd1, 7'd0, 7'd50, 7'd50, 7'd5};
    f2_mag = '{7'd20, 7'd96, 7'd127, 7'd0, 7'd0, 7'd49, 7'd50, 7'd3};
    f2_exp = '{7'd79, 7'd96, 7'd127, 7'd0, 7'd0, 7'd49, 7'd50, 7'd4};

    for (int a = 0; a < 8; a++) begin
      mag_mem[a] = 18'd50;
      bar_mem[a] = 7'd0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ctrl", {26'd0, mag_rd, cv_start, bar_we, frame_done, overrun, timeout_err}, 32'd0);
    chk("rst_data", {7'd0, mag_addr, bar_addr, bar_data, cv_in}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: all results 50 over empty bars
    base = n_wr;
    b0   = n_busy;
    pulse_start();
    wait_done(300, seen);
    chk("f1_done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("f1_nwrites", n_wr - base, 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("f1_addr%0d", k), {29'd0, wr_addr[base+k]}, (k % 2) * 4 + k / 2);
      chk($sformatf("f1_data%0d", k), {25'd0, wr_data[base+k]}, 32'd50);
      chk($sformatf("f1_lat%0d", k), wr_lat[base+k], 32'd4);
    end
    chk("f1_busy_cycles", n_busy - b0, 32'd49);
    chk("f1_done_offset", done_cyc - busy_rise, 32'd48);
    chk("f1_idle_after", {31'd0, busy}, 32'd0);

    // Frame 2: decay / attack / floor table
    for (int a = 0; a < 8; a++) begin
      mag_mem[a] = {11'd0, f2_mag[a]};
      bar_mem[a] = f2_bar[a];
    end
    base = n_wr;
    pulse_start();
    wait_done(300, seen);
    chk("f2_done_seen", {31'd0, seen}, 32'd1);

    // Frame 3 set up during frame 2 DONE, started in the following idle cycle.
    for (int a = 0; a < 8; a++) begin
      mag_mem[a] = 18'd30;
      bar_mem[a] = 7'd0;
    end
    mag_mem[0] = 18'h3FFFF;
    bar_mem[0] = 7'd40;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("f3_start_after_done", {31'd0, busy}, 32'd1);

    chk("f2_nwrites", n_wr - base, 32'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("f2_data%0d", k), {25'd0, wr_data[base+k]}, {25'd0, f2_exp[(k % 2) * 4 + k / 2]});
    chk("f2_no_timeout", {31'd0, timeout_err}, 32'd0);

    // Frame 3: first conversion times out; overrun mid-frame and in DONE
    base = n_wr;
    o0   = n_ovr;
    d0   = n_done;
    repeat (20) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done(600, seen);
    chk("f3_done_seen", {31'd0, seen}, 32'd1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("f3_overruns", n_ovr - o0, 32'd2);
    chk("f3_one_done", n_done - d0, 32'd1);
    chk("f3_no_restart", {31'd0, busy}, 32'd0);
    chk("f3_nwrites", n_wr - base, 32'd8);
    chk("f3_timeout_data", {25'd0, wr_data[base]}, 32'd39);
    chk("f3_timeout_lat", wr_lat[base], 32'd64);
    chk("f3_next_data", {25'd0, wr_data[base+1]}, 32'd30);
    chk("f3_next_lat", wr_lat[base+1], 32'd4);
    chk("f3_last_data", {25'd0, wr_data[base+7]}, 32'd30);
    chk("f3_timeout_err", {31'd0, timeout_err}, 32'd1);

    // Frame 4: reset during WAIT
    for (int a = 0; a < 8; a++) begin
      mag_mem[a] = 18'd50;
      bar_mem[a] = 7'd0;
    end
    base = n_wr;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cv_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("f4_cv_start_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("f4_rst_busy", {31'd0, busy}, 32'd0);
    chk("f4_rst_ctrl", {26'd0, mag_rd, cv_start, bar_we, frame_done, overrun, timeout_err}, 32'd0);
    chk("f4_rst_data", {7'd0, mag_addr, bar_addr, bar_data, cv_in}, 32'd0);
    w0 = n_wr;
    repeat (6) @(negedge clk);
    chk("f4_no_write_in_reset", n_wr - w0, 32'd0);
    chk("f4_no_write_before", w0 - base, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 5: restart from bin 0, channel 0
    base = n_wr;
    pulse_start();
    wait_done(300, seen);
    chk("f5_done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("f5_nwrites", n_wr - base, 32'd8);
    chk("f5_first_addr", {29'd0, wr_addr[base]}, 32'd0);
    chk("f5_first_data", {25'd0, wr_data[base]}, 32'd50);
    chk("f5_last_addr", {29'd0, wr_addr[base+7]}, 32'd7);
    chk("f5_timeout_clear", {31'd0, timeout_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
